apb_master_bridge: RTL and testbench

- Single-outstanding APB3 requester that drives the transactions our APB memory slave consumes.
- Converts a simple valid/ready command port into the APB SETUP/ACCESS sequence.
- Returns read data and error status on a one-cycle response strobe.
- Sits directly upstream of the memory slave and replaces hand-sequenced psel/penable stimulus in system and test contexts.

---
 rtl/apb_master_bridge.sv | 115 +++++++++++
 tb/tb_apb_master_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: turns a valid/ready command into a SETUP/ACCESS
// sequence and returns read data and error status on a one-cycle response strobe.
module apb_master_bridge #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // The APB address/direction/data registers double as the command latch:
  // they are loaded at the handshake and held until the response cycle.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      paddr_o       <= '0;
      pwrite_o      <= 1'b0;
      pwdata_o      <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            psel_o      <= 1'b1;
            paddr_o     <= cmd_addr_i;
            pwrite_o    <= cmd_write_i;
            pwdata_o    <= cmd_write_i ? cmd_wdata_i : '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            paddr_o       <= '0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            state         <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TIMEOUT_LAST) begin
            // Counter holds the number of earlier wait cycles, so this is the
            // TIMEOUT_CYCLES-th ACCESS cycle with pready low.
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            paddr_o       <= '0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          wait_cnt    <= '0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          wait_cnt    <= '0;
          cmd_ready_o <= 1'b1;
          psel_o      <= 1'b0;
          penable_o   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB memory slave with configurable wait,
// error and hang behaviour, and a queue of expected responses.
module tb_apb_master_bridge;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              to;
  } rsp_t;

  logic              clk = 1'b0;
  logic              preset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)
  ) dut (
    .pclk_i(clk), .preset_i(preset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  // APB memory slave model
  logic [DATA_W-1:0] mem [256];
  int slv_wait = 0;
  bit slv_hang = 1'b0;
  bit slv_err  = 1'b0;
  int acc_cnt  = 0;

  assign pready  = psel && penable && !slv_hang && (acc_cnt >= slv_wait);
  assign pslverr = slv_err && pready;
  assign prdata  = mem[paddr];

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns in the cycle after the accepting edge.
  task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input rsp_t e, input bit push);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    checks++;
    if (!cmd_ready) begin errors++; $display("FAIL accept_wait got=cmd_ready 0 exp=1"); end
    tick();
    cmd_valid = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  // Waits (bounded) for the response; lat counts cycles after the accepting edge.
  task automatic collect(output bit got, output int lat, output rsp_t obs, output rsp_t exp,
                         output bit stable);
    logic [ADDR_W+DATA_W:0] ref_bus;
    got = 1'b0; lat = 1; stable = 1'b1; obs = '0; exp = '0; ref_bus = '0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        obs.rdata = rsp_rdata; obs.err = rsp_err; obs.to = rsp_timeout;
        break;
      end
      if (i == 0) begin
        ref_bus = {paddr, pwrite, pwdata};
        if (!(psel && !penable)) stable = 1'b0;
      end else if (!(psel && penable && {paddr, pwrite, pwdata} == ref_bus)) begin
        stable = 1'b0;
      end
      tick();
      lat++;
    end
    if (exp_q.size() > 0) exp = exp_q.pop_front();
  endtask

  task automatic test_reset();
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) tick();
    preset = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
    end
    checks++; if ({paddr, pwdata, rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_bus got=%0h/%0h/%0h exp=0", paddr, pwdata, rsp_rdata);
    end
  endtask

  task automatic test_write_zero_wait();
    bit got, stable; int lat; rsp_t obs, exp;
    issue(1'b1, 8'd1, 32'd15, '{rdata: '0, err: 1'b0, to: 1'b0}, 1'b1);
    checks++; if ({psel, penable, cmd_ready} !== 3'b100) begin
      errors++; $display("FAIL wr1_setup got=psel/pen/rdy %b exp=100", {psel, penable, cmd_ready});
    end
    checks++; if ({paddr, pwrite, pwdata} !== {8'd1, 1'b1, 32'd15}) begin
      errors++; $display("FAIL wr1_setup_bus got=%0h/%b/%0h exp=1/1/f", paddr, pwrite, pwdata);
    end
    collect(got, lat, obs, exp, stable);
    checks++; if (!got) begin errors++; $display("FAIL wr1_rsp got=none exp=rsp_valid"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL wr1_latency got=%0d exp=3", lat); end
    checks++; if (obs !== exp) begin errors++; $display("FAIL wr1_rsp_data got=%0h exp=%0h", obs, exp); end
    checks++; if (!stable) begin errors++; $display("FAIL wr1_apb_seq got=unstable exp=stable"); end
    checks++; if ({psel, penable} !== 2'b00) begin errors++; $display("FAIL wr1_resp_bus got=%b exp=00", {psel, penable}); end
    tick();
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL wr1_after got=rdy/valid %b exp=10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_write_read();
    bit got, stable; int lat; rsp_t obs, exp;
    issue(1'b1, 8'd2, 32'd30, '{rdata: '0, err: 1'b0, to: 1'b0}, 1'b1);
    collect(got, lat, obs, exp, stable);
    checks++; if (!got || obs !== exp) begin errors++; $display("FAIL wr2_rsp got=%0h exp=%0h", obs, exp); end
    issue(1'b0, 8'd1, 32'hDEAD_BEEF, '{rdata: 32'd15, err: 1'b0, to: 1'b0}, 1'b1);
    checks++; if ({pwrite, pwdata} !== 33'd0) begin errors++; $display("FAIL rd1_pwdata got=%b/%0h exp=0/0", pwrite, pwdata); end
    collect(got, lat, obs, exp, stable);
    checks++; if (!got || obs !== exp) begin errors++; $display("FAIL rd1_rsp got=%0h exp=%0h", obs, exp); end
    checks++; if (!stable || lat != 3) begin errors++; $display("FAIL rd1_seq got=stable %b lat %0d exp=1/3", stable, lat); end
    issue(1'b0, 8'd2, 32'h1234_5678, '{rdata: 32'd30, err: 1'b0, to: 1'b0}, 1'b1);
    checks++; if (pwdata !== 32'd0) begin errors++; $display("FAIL rd2_pwdata got=%0h exp=0", pwdata); end
    collect(got, lat, obs, exp, stable);
    checks++; if (!got || obs !== exp) begin errors++; $display("FAIL rd2_rsp got=%0h exp=%0h", obs, exp); end
    tick();
  endtask

  task automatic test_wait_states();
    bit got, stable; int lat; rsp_t obs, exp;
    slv_wait = 3;
    issue(1'b0, 8'd1, '0, '{rdata: 32'd15, err: 1'b0, to: 1'b0}, 1'b1);
    collect(got, lat, obs, exp, stable);
    checks++; if (!got) begin errors++; $display("FAIL wait_rsp got=none exp=rsp_valid"); end
    checks++; if (lat != 6) begin errors++; $display("FAIL wait_latency got=%0d exp=6", lat); end
    checks++; if (!stable) begin errors++; $display("FAIL wait_stable got=unstable exp=stable"); end
    checks++; if (obs !== exp) begin errors++; $display("FAIL wait_rsp_data got=%0h exp=%0h", obs, exp); end
    slv_wait = 0;
    tick();
  endtask

  task automatic test_slave_error();
    bit got, stable; int lat; rsp_t obs, exp;
    slv_err = 1'b1;
    issue(1'b1, 8'd3, 32'd5, '{rdata: '0, err: 1'b1, to: 1'b0}, 1'b1);
    collect(got, lat, obs, exp, stable);
    checks++; if (!got || obs !== exp) begin errors++; $display("FAIL slverr_rsp got=%0h exp=%0h", obs, exp); end
    slv_err = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bit got, stable; int lat; rsp_t obs, exp;
    slv_hang = 1'b1;
    issue(1'b0, 8'd1, '0, '{rdata: '0, err: 1'b1, to: 1'b1}, 1'b1);
    collect(got, lat, obs, exp, stable);
    checks++; if (!got) begin errors++; $display("FAIL tmo_rsp got=none exp=rsp_valid"); end
    checks++; if (lat != 2 + TIMEOUT) begin errors++; $display("FAIL tmo_latency got=%0d exp=%0d", lat, 2 + TIMEOUT); end
    checks++; if (obs !== exp) begin errors++; $display("FAIL tmo_rsp_data got=%0h exp=%0h", obs, exp); end
    checks++; if (psel !== 1'b0) begin errors++; $display("FAIL tmo_psel got=%b exp=0", psel); end
    slv_hang = 1'b0;
    tick();
    checks++; if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout} !== 4'b1011 || rsp_rdata !== '0) begin
      errors++; $display("FAIL tmo_after got=%b/%0h exp=1011/0", {cmd_ready, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
  endtask

  task automatic test_ready_at_limit();
    bit got, stable; int lat; rsp_t obs, exp;
    slv_wait = TIMEOUT - 1;
    issue(1'b0, 8'd2, '0, '{rdata: 32'd30, err: 1'b0, to: 1'b0}, 1'b1);
    collect(got, lat, obs, exp, stable);
    checks++; if (!got || obs !== exp) begin errors++; $display("FAIL limit_rsp got=%0h exp=%0h", obs, exp); end
    checks++; if (lat != 2 + TIMEOUT) begin errors++; $display("FAIL limit_latency got=%0d exp=%0d", lat, 2 + TIMEOUT); end
    slv_wait = 0;
    tick();
  endtask

  task automatic test_reset_abort();
    bit seen;
    slv_hang = 1'b1;
    issue(1'b0, 8'd1, '0, '0, 1'b0);
    tick();
    checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL abort_access got=%b exp=11", {psel, penable}); end
    preset = 1'b1;
    tick();
    checks++; if ({psel, penable, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL abort_bus got=%b exp=000", {psel, penable, rsp_valid});
    end
    preset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid || psel) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_rsp got=activity exp=none"); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
    slv_hang = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit got, stable, saw; int lat, k; rsp_t obs, exp;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'd4; cmd_wdata = 32'd7;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    tick();
    exp_q.push_back('{rdata: '0, err: 1'b0, to: 1'b0});
    cmd_addr = 8'd5; cmd_wdata = 32'd9;
    k = 1; saw = 1'b0; obs = '0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      if (rsp_valid) begin saw = 1'b1; obs.rdata = rsp_rdata; obs.err = rsp_err; obs.to = rsp_timeout; end
      tick();
      k++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    checks++; if (k != 4) begin errors++; $display("FAIL b2b_next_ready got=%0d exp=4", k); end
    checks++; if (!saw || obs !== exp) begin errors++; $display("FAIL b2b_first_rsp got=%0h exp=%0h", obs, exp); end
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back('{rdata: '0, err: 1'b0, to: 1'b0});
    collect(got, lat, obs, exp, stable);
    checks++; if (!got || obs !== exp || {paddr, pwdata} !== '0) begin
      errors++; $display("FAIL b2b_second_rsp got=%0h exp=%0h", obs, exp);
    end
    issue(1'b0, 8'd4, '0, '{rdata: 32'd7, err: 1'b0, to: 1'b0}, 1'b1);
    collect(got, lat, obs, exp, stable);
    checks++; if (!got || obs !== exp) begin errors++; $display("FAIL b2b_rd4 got=%0h exp=%0h", obs, exp); end
    issue(1'b0, 8'd5, '0, '{rdata: 32'd9, err: 1'b0, to: 1'b0}, 1'b1);
    collect(got, lat, obs, exp, stable);
    checks++; if (!got || obs !== exp) begin errors++; $display("FAIL b2b_rd5 got=%0h exp=%0h", obs, exp); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_read();
    test_wait_states();
    test_slave_error();
    test_timeout();
    test_ready_at_limit();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
